// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply operand streamers: default sizes,
// stream state encoding and the flat-matrix element offset helper.
package matmul_pkg;

    localparam int unsigned MATMUL_N = 2;
    localparam int unsigned MATMUL_W = 3;

    typedef enum logic {
        IDLE,
        STREAM
    } mm_state_e;

    // Bit offset of element (r,c) inside a row-major flat N x N matrix of W-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                             input int unsigned n, input int unsigned w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/mm_idx_counter.sv
// Three cascaded wrap counters (k fastest, then j, then i) walking the N^3 multiply order.
// Shared by the A- and B-operand streamers.
module mm_idx_counter
    import matmul_pkg::*;
#(
    parameter int unsigned N = MATMUL_N,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [CW-1:0] o_k,
    output logic [CW-1:0] o_j,
    output logic [CW-1:0] o_i,
    output logic          o_k_wrap,
    output logic          o_j_wrap,
    output logic          o_last
);

    logic [CW-1:0] r_k;
    logic [CW-1:0] r_j;
    logic [CW-1:0] r_i;
    logic [CW-1:0] w_k_next;
    logic [CW-1:0] w_j_next;
    logic [CW-1:0] w_i_next;
    logic          w_k_max;
    logic          w_j_max;
    logic          w_i_max;

    assign w_k_max = (r_k == CW'(N - 1));
    assign w_j_max = (r_j == CW'(N - 1));
    assign w_i_max = (r_i == CW'(N - 1));

    always_comb begin
        w_k_next = r_k;
        w_j_next = r_j;
        w_i_next = r_i;
        if (i_clear) begin
            w_k_next = '0;
            w_j_next = '0;
            w_i_next = '0;
        end else if (i_advance) begin
            w_k_next = w_k_max ? '0 : r_k + 1'b1;
            if (w_k_max) begin
                w_j_next = w_j_max ? '0 : r_j + 1'b1;
                if (w_j_max) begin
                    w_i_next = w_i_max ? '0 : r_i + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k <= '0;
            r_j <= '0;
            r_i <= '0;
        end else begin
            r_k <= w_k_next;
            r_j <= w_j_next;
            r_i <= w_i_next;
        end
    end

    assign o_k      = r_k;
    assign o_j      = r_j;
    assign o_i      = r_i;
    assign o_k_wrap = w_k_max;
    assign o_j_wrap = w_k_max && w_j_max;
    assign o_last   = w_k_max && w_j_max && w_i_max;

endmodule

// File: rtl/matrix_b_streamer.sv
// Captures an N x N matrix B and streams B[k][j] in multiply order (k, then j, then i).
// Optional MATB_TRANSPOSE_EN adds a transpose input that streams B[j][k] instead.
module matrix_b_streamer
    import matmul_pkg::*;
#(
    parameter int unsigned N = MATMUL_N,
    parameter int unsigned W = MATMUL_W,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [N*N*W-1:0] matrix_in,
`ifdef MATB_TRANSPOSE_EN
    input  logic             transpose,
`endif
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     element,
    output logic [CW-1:0]    k_idx,
    output logic [CW-1:0]    col_idx,
    output logic [CW-1:0]    row_idx,
    output logic             last
);

    mm_state_e        r_state;
    mm_state_e        w_state_next;
    logic [N*N*W-1:0] r_matrix;
    logic             w_transpose;
    logic             w_load_fire;
    logic             w_xfer;
    logic             w_cnt_clear;
    logic [CW-1:0]    w_k;
    logic [CW-1:0]    w_j;
    logic [CW-1:0]    w_i;
    logic             w_k_wrap;
    logic             w_j_wrap;
    logic             w_last;
    logic             w_unused_wrap;
    logic [CW-1:0]    w_sel_row;
    logic [CW-1:0]    w_sel_col;
    logic [W-1:0]     w_elems [N][N];

    // clear in IDLE blocks the load even though load_ready is up.
    assign w_load_fire = load_valid && (r_state == IDLE) && !clear;
    assign w_xfer      = (r_state == STREAM) && out_ready && !clear;
    assign w_cnt_clear = w_load_fire || ((r_state == STREAM) && clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_matrix <= '0;
        end else if (w_load_fire) begin
            r_matrix <= matrix_in;
        end
    end

`ifdef MATB_TRANSPOSE_EN
    logic r_transpose;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_transpose <= 1'b0;
        end else if (w_load_fire) begin
            r_transpose <= transpose;
        end
    end

    assign w_transpose = r_transpose;
`else
    assign w_transpose = 1'b0;
`endif

    mm_idx_counter #(
        .N (N)
    ) u_idx_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_cnt_clear),
        .i_advance (w_xfer),
        .o_k       (w_k),
        .o_j       (w_j),
        .o_i       (w_i),
        .o_k_wrap  (w_k_wrap),
        .o_j_wrap  (w_j_wrap),
        .o_last    (w_last)
    );

    // Wrap flags are consumed by the A-side streamer only.
    assign w_unused_wrap = w_k_wrap ^ w_j_wrap;

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign w_elems[r][c] = r_matrix[elem_lsb(r, c, N, W) +: W];
        end
    end

    assign w_sel_row = w_transpose ? w_j : w_k;
    assign w_sel_col = w_transpose ? w_k : w_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_load_fire) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                if (clear) begin
                    w_state_next = IDLE;
                end else if (out_ready && w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (r_state == IDLE);
        out_valid  = (r_state == STREAM);
        last       = (r_state == STREAM) && w_last;
        element    = w_elems[w_sel_row][w_sel_col];
        k_idx      = w_k;
        col_idx    = w_j;
        row_idx    = w_i;
    end

endmodule

// File: tb/tb_matrix_b_streamer.sv
// Scoreboard bench for matrix_b_streamer: an N=2/W=3 and an N=3/W=8 instance,
// expected elements queued at stimulus time and checked by negedge monitors.
`timescale 1ns/1ps
module tb_matrix_b_streamer;

    typedef struct {
        int elem;
        int k;
        int j;
        int i;
        bit last;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q2[$];
    exp_t q3[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        lv2, lr2, clr2, ov2, or2, last2, tr2;
    logic [11:0] m2;
    logic [2:0]  el2;
    logic        k2, c2, r2;

    logic        lv3, lr3, clr3, ov3, or3, last3, tr3;
    logic [71:0] m3;
    logic [7:0]  el3;
    logic [1:0]  k3, c3, r3;

    matrix_b_streamer #(.N(2), .W(3)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv2),
        .load_ready (lr2),
        .matrix_in  (m2),
`ifdef MATB_TRANSPOSE_EN
        .transpose  (tr2),
`endif
        .clear      (clr2),
        .out_valid  (ov2),
        .out_ready  (or2),
        .element    (el2),
        .k_idx      (k2),
        .col_idx    (c2),
        .row_idx    (r2),
        .last       (last2)
    );

    matrix_b_streamer #(.N(3), .W(8)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv3),
        .load_ready (lr3),
        .matrix_in  (m3),
`ifdef MATB_TRANSPOSE_EN
        .transpose  (tr3),
`endif
        .clear      (clr3),
        .out_valid  (ov3),
        .out_ready  (or3),
        .element    (el3),
        .k_idx      (k3),
        .col_idx    (c3),
        .row_idx    (r3),
        .last       (last3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: compare the queue head whenever a valid element is presented; pop on transfer.
    always @(negedge clk) begin
        if (rst === 1'b0 && ov2 === 1'b1 && clr2 === 1'b0) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_output", 32'(el2), 32'hFFFF_FFFF);
            end else begin
                check("dut2_element", 32'(el2), q2[0].elem);
                check("dut2_k_idx", 32'(k2), q2[0].k);
                check("dut2_col_idx", 32'(c2), q2[0].j);
                check("dut2_row_idx", 32'(r2), q2[0].i);
                check("dut2_last", 32'(last2), 32'(q2[0].last));
                if (or2) void'(q2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && ov3 === 1'b1 && clr3 === 1'b0) begin
            if (q3.size() == 0) begin
                check("dut3_unexpected_output", 32'(el3), 32'hFFFF_FFFF);
            end else begin
                check("dut3_element", 32'(el3), q3[0].elem);
                check("dut3_k_idx", 32'(k3), q3[0].k);
                check("dut3_col_idx", 32'(c3), q3[0].j);
                check("dut3_row_idx", 32'(r3), q3[0].i);
                check("dut3_last", 32'(last3), 32'(q3[0].last));
                if (or3) void'(q3.pop_front());
            end
        end
    end

    // Push the first cnt entries of an N=2 stream whose elements are given in order.
    task automatic push2(input int e[8], input int cnt);
        int n;
        exp_t x;
        n = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    x.elem = e[n]; x.k = k; x.j = j; x.i = i; x.last = (n == 7);
                    if (n < cnt) q2.push_back(x);
                    n++;
                end
    endtask

    task automatic load2(input logic [11:0] m, input logic tr);
        m2 = m; tr2 = tr; lv2 = 1'b1;
        @(posedge clk); #1;
        lv2 = 1'b0;
        check("dut2_load_latency_valid", 32'(ov2), 1);
    endtask

    task automatic run2(input bit toggle);
        bit done, was_last;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            or2 = toggle ? (c % 3 == 0) : 1'b1;
            @(negedge clk);
            was_last = ov2 && or2 && last2;
            @(posedge clk); #1;
            if (was_last) begin
                check("dut2_idle_after_last_ready", 32'(lr2), 1);
                check("dut2_idle_after_last_valid", 32'(ov2), 0);
                done = 1;
            end
        end
        or2 = 1'b0;
        if (!done) check("dut2_stream_timeout", 0, 1);
    endtask

    task automatic run3();
        bit done, was_last;
        done = 0;
        or3 = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            was_last = ov3 && or3 && last3;
            @(posedge clk); #1;
            if (was_last) begin
                check("dut3_idle_after_last_ready", 32'(lr3), 1);
                done = 1;
            end
        end
        or3 = 1'b0;
        if (!done) check("dut3_stream_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int seq_std[8];
        int seq_tr[8];
        exp_t x;
        seq_std = '{0, 2, 1, 3, 0, 2, 1, 3};
        seq_tr  = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst = 1'b0;
        lv2 = 0; clr2 = 0; or2 = 0; tr2 = 0; m2 = '0;
        lv3 = 0; clr3 = 0; or3 = 0; tr3 = 0; m3 = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_load_ready", 32'(lr2), 1);
        check("reset_out_valid", 32'(ov2), 0);
        check("reset_element", 32'(el2), 0);
        check("reset_k_idx", 32'(k2), 0);
        check("reset_col_idx", 32'(c2), 0);
        check("reset_row_idx", 32'(r2), 0);
        check("reset_last", 32'(last2), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // N=2 full-rate stream.
        push2(seq_std, 8);
        load2(12'b011_010_001_000, 1'b0);
        run2(1'b0);

        // N=2 with out_ready pattern 1,0,0,...
        push2(seq_std, 8);
        load2(12'b011_010_001_000, 1'b0);
        run2(1'b1);

        // N=3, W=8, B[r][c] = 10r+c.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m3[(r*3+c)*8 +: 8] = 8'(10*r + c);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 3; k++) begin
                    x.elem = 10*k + j; x.k = k; x.j = j; x.i = i;
                    x.last = (i == 2 && j == 2 && k == 2);
                    q3.push_back(x);
                end
        lv3 = 1'b1;
        @(posedge clk); #1;
        lv3 = 1'b0;
        run3();

        // clear after the 3rd transfer, with out_ready still high.
        push2(seq_std, 3);
        load2(12'b011_010_001_000, 1'b0);
        or2 = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        or2 = 1'b0;
        check("clear_out_valid", 32'(ov2), 0);
        check("clear_load_ready", 32'(lr2), 1);
        check("clear_queue_drained", q2.size(), 0);
        push2(seq_std, 8);
        load2(12'b011_010_001_000, 1'b0);
        run2(1'b0);

        // clear in IDLE with load_valid: no load accepted.
        clr2 = 1'b1; lv2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0; lv2 = 1'b0;
        check("clear_blocks_load", 32'(ov2), 0);

        // Asynchronous reset between edges mid-stream.
        push2(seq_std, 8);
        load2(12'b011_010_001_000, 1'b0);
        or2 = 1'b1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(ov2), 0);
        check("midrst_element", 32'(el2), 0);
        check("midrst_load_ready", 32'(lr2), 1);
        q2.delete();
        or2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef MATB_TRANSPOSE_EN
        push2(seq_tr, 8);
        load2(12'b011_010_001_000, 1'b1);
        run2(1'b0);
`else
        seq_tr[0] = seq_tr[1];
`endif

        check("dut2_queue_empty", q2.size(), 0);
        check("dut3_queue_empty", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_b_streamer.md
Name: matrix_b_streamer

Overview:
- Parametrised successor to the fixed 2x2, 3-bit B-operand element selector.
- Captures one N x N matrix B of W-bit elements through a valid/ready load port.
- Streams B[k][j] in multiply order (k fastest, then column j, then result row i) through a valid/ready output port.
- Feeds the MAC datapath, which pairs each element with the matching A element.

Parameters:
- N, 2, matrix dimension (N >= 2).
- W, 3, element width in bits.
- CW, $clog2(N), index counter width (derived, not overridden).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  matrix_in is valid.
- load_ready  output  1  block can accept a matrix (IDLE only).
- matrix_in  input  N*N*W  flat matrix; element (r,c) at bits [(r*N+c)*W +: W].
- clear  input  1  synchronous abort of the current stream.
- out_valid  output  1  element and indices are valid.
- out_ready  input  1  consumer accepts the current element.
- element  output  W  B[k_idx][col_idx].
- k_idx  output  CW  inner-product index.
- col_idx  output  CW  result column j.
- row_idx  output  CW  result row pass i.
- last  output  1  final element of the full N^3 sequence.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; matrix register and counters are cleared.
  - Output values under reset: load_ready=1, out_valid=0, element=0, all indices=0, last=0.
- States: IDLE, STREAM.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid&&load_ready: capture matrix_in, zero the counters, go to STREAM.
  - Latency: out_valid is 1 in the cycle after the accepting edge, with element=B[0][0].
- STREAM:
  - load_ready=0; load_valid is ignored.
  - out_valid=1. All outputs are registered and stay stable while out_valid&&!out_ready.
  - Each transfer (out_valid&&out_ready) advances the counters:
    - k increments.
    - When k wraps N-1 to 0, j increments.
    - When j wraps, i increments.
  - Element order for N=2 matches the legacy entries 0..7: b00, b10, b01, b11, b00, b10, b01, b11.
- last:
  - Asserted when i=j=k=N-1.
  - A transfer with last=1 returns the block to IDLE. out_valid=0 and load_ready=1 in the next cycle.
  - Back-to-back matrices therefore have one idle bubble; this is intended.
- Stall: arbitrary out_ready gaps must not drop or repeat elements.
- clear:
  - In STREAM: return to IDLE next cycle and zero the counters, regardless of out_ready. The matrix register holds its value.
  - clear in IDLE while load_valid=1: clear wins and no load is accepted.
- Reset mid-stream: immediate return to the reset values; no partial transfer is reported.
- Element selection: plain indexed part-select; no arithmetic, no sign extension.

Optional Feature:
- Macro MATB_TRANSPOSE_EN.
- When defined:
  - Extra input port transpose (1 bit) is sampled together with the load handshake and held for the whole stream.
  - When the sampled value is 1, the block emits B[j][k] instead of B[k][j]. This lets the same MAC compute A x B^T.
  - Index outputs are unchanged.
- When undefined: no port is added and the block always emits B[k][j].

Decomposition:
- Shared package matmul_pkg holds:
  - Default N and W.
  - State enum {IDLE, STREAM}.
  - Function elem_lsb(r,c,N,W) returning (r*N+c)*W, shared with the A-operand streamer.
- Sub-module mm_idx_counter: three cascaded wrap counters with an advance input. It outputs k, j, i, wrap flags and last. It is reused by the A-side streamer.

Test Plan:
- N=2, W=3, matrix_in=12'b011_010_001_000 (b00=0, b01=1, b10=2, b11=3), out_ready=1 -> elements 0,2,1,3,0,2,1,3 on consecutive cycles; last on the 8th only; load_ready=1 on the cycle after.
- Same matrix, out_ready toggling 1,0,0,1,... -> identical 8-element sequence, no duplicates; element is held during the 0 cycles.
- N=3, W=8, B[r][c]=10*r+c -> 27 transfers; the first 6 are 0,10,20,1,11,21; last on the 27th with element=22.
- clear asserted after the 3rd transfer -> out_valid=0 next cycle; a new load then restarts at B[0][0].
- rst pulsed mid-stream between clock edges -> out_valid and element go to 0 immediately; load_ready=1.
- MATB_TRANSPOSE_EN defined, transpose=1, N=2 matrix from the first test -> sequence 0,1,2,3,0,1,2,3.
